// File: rtl/mask_sched_pkg.sv
// rtl/mask_sched_pkg.sv - shared constants, state type and lane-index helper for mask_index_scheduler
// Contents: MASK_W/IDX_W/CNT_W widths, state_t FSM encoding, lane_index() rank-to-index selector.
package mask_sched_pkg;

    localparam int MASK_W = 128;
    localparam int IDX_W  = 7;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // Returns the position of the set bit whose exclusive prefix count equals
    // rank. At most one set bit can match a given rank, so OR-ing the matching
    // positions is a one-hot encode; no match yields 0.
    function automatic logic [IDX_W-1:0] lane_index(
        input logic [MASK_W-1:0]       mask,
        input logic [MASK_W*IDX_W-1:0] psum,
        input logic [CNT_W-1:0]        rank
    );
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i] && ({1'b0, psum[i*IDX_W +: IDX_W]} == rank)) begin
                r = r | IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/excl_prefix_count.sv
// rtl/excl_prefix_count.sv - combinational log-depth exclusive prefix popcount over a 128-bit mask
// Ports: i_mask (mask in), o_psum (128 x IDX_W exclusive counts, lane i at [i*IDX_W+:IDX_W]),
//        o_total (CNT_W popcount of the whole mask, 0..128).
module excl_prefix_count
    import mask_sched_pkg::*;
(
    input  logic [MASK_W-1:0]       i_mask,
    output logic [MASK_W*IDX_W-1:0] o_psum,
    output logic [CNT_W-1:0]        o_total
);

    localparam int LEVELS = $clog2(MASK_W);

    // Scanning the mask shifted up by one gives exclusive counts directly;
    // the largest exclusive count is 127, so every level fits in IDX_W bits.
    logic [IDX_W-1:0] w_lvl [0:LEVELS][0:MASK_W-1];

    genvar d, i;
    generate
        for (i = 0; i < MASK_W; i++) begin : g_seed
            if (i == 0) begin : g_zero
                assign w_lvl[0][i] = '0;
            end else begin : g_bit
                assign w_lvl[0][i] = {{(IDX_W-1){1'b0}}, i_mask[i-1]};
            end
        end

        // Kogge-Stone style scan: level d adds the partial sum 2^d lanes below.
        for (d = 0; d < LEVELS; d++) begin : g_level
            for (i = 0; i < MASK_W; i++) begin : g_lane
                if (i >= (1 << d)) begin : g_add
                    assign w_lvl[d+1][i] = w_lvl[d][i] + w_lvl[d][i-(1<<d)];
                end else begin : g_pass
                    assign w_lvl[d+1][i] = w_lvl[d][i];
                end
            end
        end

        for (i = 0; i < MASK_W; i++) begin : g_out
            assign o_psum[i*IDX_W +: IDX_W] = w_lvl[LEVELS][i];
        end
    endgenerate

    assign o_total = {1'b0, w_lvl[LEVELS][MASK_W-1]} + {{(CNT_W-1){1'b0}}, i_mask[MASK_W-1]};

endmodule

// File: rtl/mask_index_scheduler.sv
// rtl/mask_index_scheduler.sv - streams ascending indices of set mask bits, LANES per beat
// Ports: clk/reset (async active-high); in_valid/in_ready/in_mask mask intake;
//        out_valid/out_ready/out_idx/out_lane_valid/out_last index stream;
//        count (popcount of current mask), busy (not idle).
module mask_index_scheduler
    import mask_sched_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MASK_W-1:0]       in_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*IDX_W-1:0]  out_idx,
    output logic [LANES-1:0]        out_lane_valid,
    output logic                    out_last,
    output logic [CNT_W-1:0]        count,
    output logic                    busy
);

    state_t                    r_state;
    logic [MASK_W-1:0]         r_mask;
    logic [MASK_W*IDX_W-1:0]   r_psum;
    logic [CNT_W-1:0]          r_count;
    logic [CNT_W-1:0]          r_base;

    logic [MASK_W*IDX_W-1:0]   w_psum;
    logic [CNT_W-1:0]          w_total;
    logic                      w_emit;
    logic                      w_last;

    excl_prefix_count u_prefix (
        .i_mask  (r_mask),
        .o_psum  (w_psum),
        .o_total (w_total)
    );

    assign w_emit = (r_state == ST_EMIT);
    // Nine-bit compare so base+LANES cannot wrap when count is 128.
    assign w_last = ({1'b0, r_base} + 9'(LANES)) >= {1'b0, r_count};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_psum  <= '0;
            r_count <= '0;
            r_base  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mask  <= in_mask;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_psum  <= w_psum;
                    r_count <= w_total;
                    r_base  <= '0;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_base <= r_base + CNT_W'(LANES);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            logic [CNT_W-1:0] w_rank;
            assign w_rank = r_base + CNT_W'(k);
            assign out_lane_valid[k] = w_emit && (w_rank < r_count);
            assign out_idx[k*IDX_W +: IDX_W] = out_lane_valid[k] ? lane_index(r_mask, r_psum, w_rank) : '0;
        end
    endgenerate

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = w_emit;
    assign out_last  = w_emit && w_last;
    // During CALC the total is already available from the registered mask.
    assign count     = (r_state == ST_CALC) ? w_total : r_count;

endmodule

// File: tb/tb_mask_index_scheduler.sv
// tb/tb_mask_index_scheduler.sv - scoreboard bench for mask_index_scheduler
module tb_mask_index_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_mask;
    logic         out_valid;
    logic         out_ready;
    logic [27:0]  out_idx;
    logic [3:0]   out_lane_valid;
    logic         out_last;
    logic [7:0]   count;
    logic         busy;

    mask_index_scheduler #(.LANES(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mask        (in_mask),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_idx        (out_idx),
        .out_lane_valid (out_lane_valid),
        .out_last       (out_last),
        .count          (count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] idx;
        logic [3:0]  lv;
        logic        last;
        logic [7:0]  cnt;
        logic        first;
    } beat_t;

    beat_t sb[$];
    int    lat_q[$];
    int    checks = 0;
    int    errs = 0;
    int    cyc = 0;
    int    beats_seen = 0;
    logic  lat_done = 1'b0;
    int    rmode = 0;
    logic  forced = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #2;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = forced;
        endcase
    end

    // Reference: list set positions in ascending order and chunk them by four.
    task automatic push_model(input logic [127:0] m);
        int    idxs[$];
        int    n, nb, j;
        beat_t b;
        for (int i = 0; i < 128; i++) if (m[i]) idxs.push_back(i);
        n  = idxs.size();
        nb = (n == 0) ? 1 : (n + 3) / 4;
        for (int bi = 0; bi < nb; bi++) begin
            b.idx = '0;
            b.lv  = '0;
            for (int k = 0; k < 4; k++) begin
                j = bi * 4 + k;
                if (j < n) begin
                    b.idx[k*7 +: 7] = 7'(idxs[j]);
                    b.lv[k] = 1'b1;
                end
            end
            b.last  = (bi == nb - 1);
            b.cnt   = 8'(n);
            b.first = (bi == 0);
            sb.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!reset && out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errs++;
                $display("FAIL in_ready_during_emit got=%b exp=0", in_ready);
            end
            checks++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_beat got out_valid=1 exp no beat pending");
            end else begin
                e = sb[0];
                if (e.first && !lat_done && lat_q.size() > 0) begin
                    checks++;
                    if (cyc != lat_q[0]) begin
                        errs++;
                        $display("FAIL first_beat_latency got cycle=%0d exp cycle=%0d", cyc, lat_q[0]);
                    end
                    lat_done = 1'b1;
                end
                if (out_idx !== e.idx || out_lane_valid !== e.lv || out_last !== e.last || count !== e.cnt) begin
                    errs++;
                    $display("FAIL beat got idx=%h lv=%b last=%b cnt=%0d exp idx=%h lv=%b last=%b cnt=%0d",
                             out_idx, out_lane_valid, out_last, count, e.idx, e.lv, e.last, e.cnt);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    if (e.first && lat_q.size() > 0) void'(lat_q.pop_front());
                    lat_done = 1'b0;
                    beats_seen++;
                end
            end
        end
    end

    task automatic send(input logic [127:0] m);
        int n;
        push_model(m);
        @(negedge clk);
        in_valid = 1'b1;
        in_mask  = m;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout got in_ready=0 exp 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mask  = {$urandom, $urandom, $urandom, $urandom};
        lat_q.push_back(cyc + 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout got pending=%0d exp 0", sb.size());
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            out_lane_valid !== 4'b0 || out_idx !== 28'b0 || out_last !== 1'b0) begin
            errs++;
            $display("FAIL %s got valid=%b ready=%b busy=%b lv=%b idx=%h last=%b exp 0 1 0 0 0 0",
                     name, out_valid, in_ready, busy, out_lane_valid, out_idx, out_last);
        end
    endtask

    initial begin
        logic [127:0] m;
        int p, bs, n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_mask  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        checks++;
        if (count !== 8'd0) begin
            errs++;
            $display("FAIL reset_count got=%0d exp=0", count);
        end
        #1 reset = 1'b0;

        rmode = 0;
        send(128'h13);            wait_idle();
        send({128{1'b1}});        wait_idle();
        send(128'h0);             wait_idle();
        check_idle_outputs("idle_after_empty");
        send(128'h1 << 127);      wait_idle();

        // Backpressure: hold beat 0 of 0xFF for three cycles.
        rmode  = 2;
        forced = 1'b0;
        send(128'hFF);
        repeat (4) @(posedge clk);
        #1 forced = 1'b1;
        wait_idle();
        rmode = 0;

        // Reset while beat 5 of an all-ones mask is on the output.
        bs = beats_seen;
        send({128{1'b1}});
        n = 0;
        while (beats_seen != bs + 5 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errs++;
            $display("FAIL beat5_timeout got beats=%0d exp=%0d", beats_seen - bs, 5);
        end
        #2 reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_stream");
        sb.delete();
        lat_q.delete();
        lat_done = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        send(128'h13);
        wait_idle();

        // Randomised masks of varied density under random backpressure.
        rmode = 1;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 5))
                0: p = 0;
                1: p = 3;
                2: p = 25;
                3: p = 50;
                4: p = 90;
                default: p = 100;
            endcase
            for (int i = 0; i < 128; i++) m[i] = ($urandom_range(0, 99) < p);
            send(m);
        end
        wait_idle();
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/mask_index_scheduler.md
# mask_index_scheduler

Sequencing controller around a 128-lane exclusive prefix-count datapath. It accepts one 128-bit redundancy mask per transaction and computes each set bit's compacted position. It then streams the original indices of the set bits, `LANES` per beat, in ascending order to the downstream gather/compaction stage. It sits between the redundancy detector (mask producer) and the operand fetch unit (index consumer).

## Interface
- `MASK_W`, 128, mask width (fixed at 128 for this revision)
- `IDX_W`, 7, width of one index / prefix-count value
- `CNT_W`, 8, width of the total set-bit count (0..128)
- `LANES`, 4, indices emitted per output beat (power of two, 1..16)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  mask available
- `in_ready`  out  1  block accepts a mask
- `in_mask`  in  128  bit i set = element i is non-redundant
- `out_valid`  out  1  beat available
- `out_ready`  in  1  consumer accepts beat
- `out_idx`  out  LANES*7  lane k index at `[k*7+:7]`
- `out_lane_valid`  out  LANES  lane k carries a real index
- `out_last`  out  1  final beat of the current mask
- `count`  out  8  popcount of the current mask, valid from CALC onward
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, CALC, EMIT.
- **IDLE:** `in_ready`=1. A handshake (`in_valid && in_ready`) registers `in_mask` into `mask_q`; next state is CALC.
- **CALC:** exclusive prefix counts are registered into `psum_q[i]` (7b). `psum_q[i]` = number of set bits in `mask_q[i-1:0]`. `count` = popcount(`mask_q`), 8b, no wrap (128 → 8'd128). `base` clears to 0. Next state is EMIT.
- **EMIT:** `out_valid`=1.
  - Lane k valid iff `base+k < count`.
  - `out_idx` lane k = the unique i with `mask_q[i] && psum_q[i]==base+k`. Invalid lanes drive 0.
  - `out_last`=1 iff `base+LANES >= count`.
  - On `out_valid && out_ready`: if `out_last`, go to IDLE; else `base += LANES`.
  - `base` is 8b, so no overflow at `count`=128.
- **Empty mask (`count`=0):** exactly one beat, with `out_lane_valid`=0, `out_idx`=0 and `out_last`=1. Consumers always see a terminator.
- **Backpressure:** while `out_valid && !out_ready`, all outputs are held stable.
- **Reset** (any time, including mid-EMIT): state=IDLE, `mask_q`=0, `psum_q`=0, `base`=0, `count`=0. Outputs: `out_valid`=0, `out_lane_valid`=0, `out_idx`=0, `out_last`=0, `busy`=0, `in_ready`=1. The partially streamed mask is discarded.
- `in_ready`=0 in CALC and EMIT. There is no overlap between masks.

## Timing
- Mask accepted on edge t (end of IDLE cycle). CALC occupies cycle t+1. First beat is visible in cycle t+2.
- Beats per mask = max(1, ceil(`count`/LANES)).
- Occupancy per mask = 2 + beats cycles at full `out_ready`. A new mask can be accepted in the cycle after the last-beat handshake.
- Outputs are registered or decoded from registered state only. There is no combinational path from `in_*` to `out_*`, and none from `out_ready` to `out_*`.
- The prefix computation is the critical path. It is confined to the `mask_q` → `psum_q` stage.

## Structure
- Package `mask_sched_pkg`:
  - state enum {IDLE, CALC, EMIT}
  - `MASK_W`, `IDX_W`, `CNT_W` constants
  - lane-index extraction helper function
- Sub-module `excl_prefix_count`: combinational, 128-bit mask in, 128×7b exclusive prefix counts plus 8b total out. Implemented as a log-depth parallel-prefix network.
- Top holds the FSM, `base` counter and per-lane one-hot match/encode (128:1 selection per lane).

## Test plan
- Mask `128'h13`, `out_ready`=1 → one beat at t+2:
  - lanes 0..2 = 0, 1, 4
  - `out_lane_valid`=4'b0111, `out_last`=1, `count`=3
- Mask all-ones → 32 beats:
  - beat j carries indices 4j..4j+3 with `out_lane_valid`=4'b1111
  - `out_last` only on beat 31; `count`=128
- Mask 0 → one beat: `out_lane_valid`=0, `out_last`=1, `count`=0, then IDLE.
- Mask with only bit 127 set → one beat: lane0=127, `out_lane_valid`=4'b0001, `out_last`=1.
- Backpressure: mask `128'hFF`, with `out_ready` low for 3 cycles during beat 0:
  - beat 0 (0..3) held stable
  - then beat 1 (4..7) with `out_last`=1
- Reset mid-stream: all-ones mask, assert `reset` during beat 5:
  - `out_valid`=0 and `in_ready`=1 immediately
  - after release, mask `128'h13` produces the correct single beat.
